// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-ported RAM between instruction fetch and
// data accesses, with wait-state handling, timeout/error trapping, LL/SC link
// tracking and a halt quiesce.
//
// Handshake: requests are level-sensitive. A requester raises iREN, or dREN/dWEN,
// with address and data stable and holds them until the cycle its hit is 1.
// The hit cycle is the transfer cycle. Dropping the request before the hit
// cancels the access: no hit is produced and the arbiter returns to IDLE.
module memory_arbiter #(
   parameter int TIMEOUT = 64,
   parameter bit LINK_EN = 1'b1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        ihit,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic        datomic,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dhit,
   output logic [31:0] dload,
   input  logic        halt,
   output logic        halted,
   output logic        err,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic [1:0]  ramstate,
   output logic [2:0]  state_dbg
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      DREQ   = 3'd1,
      IREQ   = 3'd2,
      SCFAIL = 3'd3,
      HALTED = 3'd4,
      ERR    = 3'd5
   } state_t;

   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam logic [1:0] RAM_ERROR  = 2'd3;
   localparam int         CW         = $clog2(TIMEOUT);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           link_valid;
   logic [31:0]    link_addr;
   logic           last_d;

   logic d_req;
   logic is_sc;
   logic is_ll;
   logic link_ok;
   logic access;
   logic ram_err;

   assign d_req   = dREN | dWEN;
   assign is_sc   = dWEN & datomic;
   assign is_ll   = dREN & datomic & ~dWEN;
   assign link_ok = !LINK_EN || (link_valid && (link_addr == daddr));
   assign access  = (ramstate == RAM_ACCESS);
   assign ram_err = (ramstate == RAM_ERROR);

   assign state_dbg = state;
   assign halted    = (state == HALTED);
   assign err       = (state == ERR);

   // RAM strobes, hits and load data decoded from the current grant and inputs
   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = 32'd0;
      ramstore = 32'd0;
      ihit     = 1'b0;
      iload    = 32'd0;
      dhit     = 1'b0;
      dload    = 32'd0;
      case (state)
         DREQ: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;  // write wins so the strobes stay exclusive
            if (d_req && access) begin
               dhit  = 1'b1;
               dload = is_sc ? 32'd1 : ramload;
            end
         end
         IREQ: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            if (iREN && access) begin
               ihit  = 1'b1;
               iload = ramload;
            end
         end
         SCFAIL: begin
            dhit  = 1'b1;
            dload = 32'd0;
         end
         default: ;
      endcase
   end

   // Grant FSM with wait-state counter, fairness bit and LL/SC link register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state      <= IDLE;
         cnt        <= '0;
         link_valid <= 1'b0;
         link_addr  <= 32'd0;
         last_d     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (halt && !d_req) begin
                  state <= HALTED;
               end else if (is_sc && !link_ok) begin
                  state      <= SCFAIL;
                  link_valid <= 1'b0;
               end else if (d_req && !(iREN && last_d)) begin
                  state <= DREQ;
                  cnt   <= '0;
               end else if (iREN) begin
                  state <= IREQ;
                  cnt   <= '0;
               end
            end
            DREQ: begin
               if (!d_req) begin
                  state <= IDLE;
               end else if (ram_err) begin
                  state <= ERR;
               end else if (access) begin
                  state  <= IDLE;
                  last_d <= 1'b1;
                  if (is_ll) begin
                     link_valid <= 1'b1;
                     link_addr  <= daddr;
                  end else if (is_sc) begin
                     link_valid <= 1'b0;
                  end else if (dWEN && (daddr == link_addr)) begin
                     link_valid <= 1'b0;
                  end
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state <= ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            IREQ: begin
               if (!iREN) begin
                  state <= IDLE;
               end else if (ram_err) begin
                  state <= ERR;
               end else if (access) begin
                  state  <= IDLE;
                  last_d <= 1'b0;
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  state <= ERR;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SCFAIL: begin
               state  <= IDLE;
               last_d <= 1'b1;
            end
            HALTED: state <= HALTED;
            ERR:    state <= ERR;
            default: state <= ERR;
         endcase
      end
   end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table of single transactions against a small RAM model,
// plus hand-written sequences for fetch streaming, alternation, abort, halt,
// reset and the error paths. Hits are checked through an expected queue.
module tb_memory_arbiter;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN, dREN, dWEN, datomic, halt;
   logic [31:0] iaddr, daddr, dstore;
   logic        ihit, dhit, halted, err, ramREN, ramWEN;
   logic [31:0] iload, dload, ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;
   logic [2:0]  state_dbg;

   memory_arbiter #(.TIMEOUT(64), .LINK_EN(1'b1)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
      .dREN(dREN), .dWEN(dWEN), .datomic(datomic), .daddr(daddr),
      .dstore(dstore), .dhit(dhit), .dload(dload),
      .halt(halt), .halted(halted), .err(err),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
      .state_dbg(state_dbg)
   );

   // clock and counters
   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_err = 0;

   logic [33:0] exp_q[$];
   logic [33:0] sb_e;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // RAM model: configurable BUSY count per access, forced BUSY, forced ERROR
   logic [31:0] mem [256];
   logic [1:0]  ram_mode = 2'd0;
   int          busy_target = 0;
   int          wait_cnt;

   always_comb begin
      if (!(ramREN || ramWEN))  ramstate = 2'd0;
      else if (ram_mode == 2'd2) ramstate = 2'd3;
      else if (ram_mode == 2'd1) ramstate = 2'd1;
      else if (wait_cnt >= busy_target) ramstate = 2'd2;
      else ramstate = 2'd1;
   end

   assign ramload = mem[ramaddr[7:0]];

   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'hC0DE0000 + i;
         wait_cnt <= 0;
      end else begin
         if ((ramREN || ramWEN) && ramstate == 2'd1) wait_cnt <= wait_cnt + 1;
         else wait_cnt <= 0;
         if (ramWEN && ramstate == 2'd2) mem[ramaddr[7:0]] <= ramstore;
      end
   end

   // scoreboard: every hit pops one expectation {kind, data}; kind 01=I, 10=D
   always @(negedge CLK) begin
      if (!RST) begin
         if (ramREN || ramWEN) check("strobe_excl", {63'd0, ramREN & ramWEN}, 64'd0);
         if (ihit || dhit) begin
            if (exp_q.size() == 0) begin
               check("unexpected_hit", {62'd0, dhit, ihit}, 64'd0);
            end else begin
               sb_e = exp_q.pop_front();
               check("sb_hit", {30'd0, dhit, ihit, (dhit ? dload : iload)}, {30'd0, sb_e});
            end
         end
      end
   end

   // stimulus records
   typedef struct {
      bit          is_i;
      bit          ren;
      bit          wen;
      bit          atom;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          busy;
      logic [31:0] exp_data;
      bit          exp_wen;
   } vec_t;

   vec_t vt[19];

   function automatic vec_t mk(bit is_i, bit ren, bit wen, bit atom, logic [31:0] addr,
                               logic [31:0] wdata, int busy, logic [31:0] exp_data, bit exp_wen);
      vec_t v;
      v.is_i = is_i; v.ren = ren; v.wen = wen; v.atom = atom; v.addr = addr;
      v.wdata = wdata; v.busy = busy; v.exp_data = exp_data; v.exp_wen = exp_wen;
      return v;
   endfunction

   // driver tasks
   task automatic clear_inputs();
      iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0; datomic = 1'b0;
      daddr = 32'd0; dstore = 32'd0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_inputs();
      halt = 1'b0;
      ram_mode = 2'd0;
      busy_target = 0;
      exp_q.delete();
      @(posedge CLK); @(posedge CLK); #1;
      RST = 1'b0;
   endtask

   task automatic wait_hit(input bit is_i, output int lat, output bit saw_wen);
      lat = 0;
      saw_wen = 1'b0;
      for (int c = 1; c <= 100; c++) begin
         @(negedge CLK);
         if (ramWEN) saw_wen = 1'b1;
         if (is_i ? ihit : dhit) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int lat;
      bit wen;
      iREN = v.is_i; iaddr = v.addr;
      dREN = v.ren;  dWEN = v.wen; datomic = v.atom;
      daddr = v.addr; dstore = v.wdata;
      busy_target = v.busy;
      exp_q.push_back({(v.is_i ? 2'b01 : 2'b10), v.exp_data});
      wait_hit(v.is_i, lat, wen);
      check({name, "_latency"}, 64'(lat), 64'(2 + v.busy));
      check({name, "_ramwen"}, {63'd0, wen}, {63'd0, v.exp_wen});
      if (lat == 0) exp_q.delete();
      @(posedge CLK); #1;
      clear_inputs();
   endtask

   int lat_a, lat_b, lat_c, nd, ni;
   bit flag;

   initial begin
      clear_inputs();
      halt = 1'b0;
      // table: LW/SW/LL/SC/fetch transactions, memory word i starts as C0DE0000+i
      vt[0]  = mk(1, 0, 0, 0, 32'h040, 32'h0,        0, 32'hC0DE0040, 0);
      vt[1]  = mk(1, 0, 0, 0, 32'h041, 32'h0,        1, 32'hC0DE0041, 0);
      vt[2]  = mk(0, 1, 0, 0, 32'h010, 32'h0,        0, 32'hC0DE0010, 0);
      vt[3]  = mk(0, 0, 1, 0, 32'h010, 32'h12345678, 1, 32'hC0DE0010, 1);
      vt[4]  = mk(0, 1, 0, 0, 32'h010, 32'h0,        3, 32'h12345678, 0);
      vt[5]  = mk(1, 0, 0, 0, 32'h000, 32'h0,        2, 32'hC0DE0000, 0);
      vt[6]  = mk(0, 1, 0, 1, 32'h100, 32'h0,        0, 32'hC0DE0000, 0);
      vt[7]  = mk(0, 0, 1, 1, 32'h100, 32'hDEAD0001, 0, 32'h00000001, 1);
      vt[8]  = mk(0, 1, 0, 1, 32'h100, 32'h0,        1, 32'hDEAD0001, 0);
      vt[9]  = mk(0, 0, 1, 0, 32'h100, 32'h00000055, 0, 32'hDEAD0001, 1);
      vt[10] = mk(0, 0, 1, 1, 32'h100, 32'h00000077, 0, 32'h00000000, 0);
      vt[11] = mk(0, 1, 0, 0, 32'h100, 32'h0,        0, 32'h00000055, 0);
      vt[12] = mk(0, 0, 1, 1, 32'h104, 32'h000000AB, 0, 32'h00000000, 0);
      vt[13] = mk(0, 1, 0, 1, 32'h104, 32'h0,        0, 32'hC0DE0004, 0);
      vt[14] = mk(0, 0, 1, 0, 32'h200, 32'h00000099, 0, 32'h00000055, 1);
      vt[15] = mk(0, 0, 1, 1, 32'h104, 32'h000000AB, 2, 32'h00000001, 1);
      vt[16] = mk(0, 1, 0, 0, 32'h104, 32'h0,        0, 32'h000000AB, 0);
      vt[17] = mk(0, 1, 0, 1, 32'h108, 32'h0,        0, 32'hC0DE0008, 0);
      vt[18] = mk(0, 0, 1, 1, 32'h10C, 32'h00000001, 0, 32'h00000000, 0);

      do_reset();
      @(negedge CLK);
      check("rst_flags", {58'd0, ihit, dhit, halted, err, ramREN, ramWEN}, 64'd0);
      check("rst_ram_bus", {ramaddr, ramstore}, 64'd0);
      check("rst_loads", {iload, dload}, 64'd0);
      check("rst_state", {61'd0, state_dbg}, 64'd0);
      @(posedge CLK); #1;

      for (int i = 0; i < 19; i++) run_vec(vt[i], $sformatf("vec%0d", i));

      // fetch streaming: a grant every 2 cycles
      iREN = 1'b1; iaddr = 32'h40; busy_target = 0;
      for (int k = 0; k < 3; k++) exp_q.push_back({2'b01, 32'hC0DE0040});
      ni = 0; lat_a = 0; lat_b = 0; lat_c = 0;
      for (int c = 1; c <= 12 && ni < 3; c++) begin
         @(negedge CLK);
         if (ihit) begin
            ni++;
            if (ni == 1) lat_a = c; else if (ni == 2) lat_b = c; else lat_c = c;
         end
         @(posedge CLK); #1;
         if (ni == 3) iREN = 1'b0;
      end
      check("fetch_stream_hits", {lat_a, lat_b}, {32'd2, 32'd4});
      check("fetch_stream_third", 64'(lat_c), 64'd6);
      clear_inputs();

      // data and fetch together: D, I, D alternation
      dREN = 1'b1; daddr = 32'h11; iREN = 1'b1; iaddr = 32'h42;
      exp_q.push_back({2'b10, 32'hC0DE0011});
      exp_q.push_back({2'b01, 32'hC0DE0042});
      exp_q.push_back({2'b10, 32'hC0DE0012});
      nd = 0; ni = 0; lat_a = 0; lat_b = 0; lat_c = 0;
      for (int c = 1; c <= 20 && (nd < 2 || ni < 1); c++) begin
         @(negedge CLK);
         if (dhit) begin nd++; if (nd == 1) lat_a = c; else lat_c = c; end
         if (ihit) begin ni++; lat_b = c; end
         @(posedge CLK); #1;
         if (nd == 1) daddr = 32'h12;
         if (nd == 2) dREN = 1'b0;
         if (ni == 1) iREN = 1'b0;
      end
      check("alt_d_then_i", {lat_a, lat_b}, {32'd2, 32'd4});
      check("alt_second_d", 64'(lat_c), 64'd6);
      clear_inputs();

      // abort: drop dREN while the RAM is still BUSY
      dREN = 1'b1; daddr = 32'h20; busy_target = 5;
      @(posedge CLK); #1;
      @(posedge CLK); #1;
      dREN = 1'b0;
      @(negedge CLK);
      check("abort_no_strobe", {62'd0, ramREN, dhit}, 64'd0);
      @(negedge CLK);
      check("abort_idle", {61'd0, state_dbg}, 64'd0);
      @(posedge CLK); #1;

      // halt arriving mid-DREQ waits for the access, then quiesces
      dREN = 1'b1; daddr = 32'h30; busy_target = 3;
      exp_q.push_back({2'b10, 32'hC0DE0030});
      lat_a = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         if (dhit) begin lat_a = c; break; end
         @(posedge CLK); #1;
         if (c == 1) halt = 1'b1;
      end
      check("halt_access_done", 64'(lat_a), 64'd5);
      @(posedge CLK); #1;
      clear_inputs();
      @(negedge CLK);
      @(negedge CLK);
      check("halted_set", {63'd0, halted}, 64'd1);
      @(posedge CLK); #1;
      iREN = 1'b1; iaddr = 32'h40;
      flag = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge CLK);
         if (ramREN || ihit) flag = 1'b1;
      end
      check("halted_ignores_fetch", {63'd0, flag}, 64'd0);
      check("halted_sticky", {63'd0, halted}, 64'd1);
      do_reset();

      // reset in the middle of a fetch; link must be gone afterwards
      run_vec(mk(0, 1, 0, 1, 32'h300, 32'h0, 0, 32'hC0DE0000, 0), "ll_before_rst");
      iREN = 1'b1; iaddr = 32'h50; busy_target = 10;
      @(negedge CLK);
      @(negedge CLK);
      check("ireq_strobe", {63'd0, ramREN}, 64'd1);
      #1 RST = 1'b1;
      #1;
      check("rst_async_strobe", {62'd0, ramREN, ihit}, 64'd0);
      check("rst_async_state", {61'd0, state_dbg}, 64'd0);
      clear_inputs();
      exp_q.delete();
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      check("post_rst_flags", {58'd0, ihit, dhit, halted, err, ramREN, ramWEN}, 64'd0);
      check("post_rst_bus", {ramaddr, dload}, 64'd0);
      @(posedge CLK); #1;
      run_vec(mk(0, 0, 1, 1, 32'h300, 32'h1, 0, 32'h0, 0), "sc_after_rst");

      // timeout: RAM BUSY forever
      ram_mode = 2'd1;
      dREN = 1'b1; daddr = 32'h10;
      lat_a = 0;
      for (int c = 1; c <= 80; c++) begin
         @(negedge CLK);
         if (err) begin lat_a = c; break; end
      end
      check("timeout_cycle", 64'(lat_a), 64'd66);
      check("timeout_strobes", {62'd0, ramREN, ramWEN}, 64'd0);
      do_reset();

      // RAM ERROR response, err sticky
      ram_mode = 2'd2;
      iREN = 1'b1; iaddr = 32'h40;
      lat_a = 0;
      for (int c = 1; c <= 10; c++) begin
         @(negedge CLK);
         if (err) begin lat_a = c; break; end
      end
      check("ram_error_cycle", 64'(lat_a), 64'd3);
      @(posedge CLK); #1;
      clear_inputs();
      ram_mode = 2'd0;
      repeat (3) @(negedge CLK);
      check("err_sticky", {61'd0, err, ramREN, ihit}, 64'd4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
